// File: rtl/multi_chn_fifo_arbiter.sv
// Per-channel ADC sample FIFOs merged round-robin into one external-FIFO word stream (CHN_TAG_EN adds a header word per sample).
// Latency: sample strobed in cycle t leaves with out_en in t+2; backpressure: out_full gates each word decision, a registered out_en is never revoked.

// Generic synchronous FIFO with combinational head; writes when full and pops when empty are ignored.
// Flush and reset override any write or pop in the same cycle.
module mcfa_fifo #(
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush_i,
  input  logic         wr_vld_i,
  input  logic [W-1:0] wr_dat_i,
  input  logic         rd_rdy_i,
  output logic [W-1:0] rd_dat_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_wr, do_rd;

  assign full_o   = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o  = (cnt_q == '0);
  assign do_wr    = wr_vld_i & ~full_o;
  assign do_rd    = rd_rdy_i & ~empty_o;
  assign rd_dat_o = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (!reset_n || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + AW'(1);
      if (do_rd) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wr_dat_i;
  end
endmodule

module multi_chn_fifo_arbiter #(
  parameter int NUM_CHN    = 2,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      rst_all_fifo,
  input  logic [NUM_CHN-1:0]        chn_enable,
  input  logic [NUM_CHN*DATA_W-1:0] chn_din,
  input  logic [NUM_CHN-1:0]        chn_din_en,
  input  logic                      out_full,
  output logic [DATA_W-1:0]         out_din,
  output logic                      out_en,
  output logic [NUM_CHN-1:0]        overflow,
  output logic                      all_empty
);
  localparam int IW = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       rr_q, rr_d, gnt_idx, rr_nxt, sel;
  logic                cand;
  int                  idx;
  logic [NUM_CHN-1:0]  pop, full, empty, wr_req, ovf_q, ovf_d;
  logic [DATA_W-1:0]   head [NUM_CHN];
  logic                out_en_q, out_en_d;
  logic [DATA_W-1:0]   out_din_q, out_din_d;
`ifdef CHN_TAG_EN
  logic [IW-1:0]       gnt_q, gnt_d;
`endif

  assign wr_req = chn_din_en & chn_enable;
  // A full FIFO drops the sample; only enabled channels can flag overflow.
  assign ovf_d  = ovf_q | (wr_req & full);

  for (genvar i = 0; i < NUM_CHN; i++) begin : g_chn
    mcfa_fifo #(.W(DATA_W), .AW(DEPTH_LOG2)) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush_i  (rst_all_fifo),
      .wr_vld_i (wr_req[i]),
      .wr_dat_i (chn_din[i*DATA_W +: DATA_W]),
      .rd_rdy_i (pop[i]),
      .rd_dat_o (head[i]),
      .full_o   (full[i]),
      .empty_o  (empty[i])
    );
  end

  // Round-robin search starting at rr_q, wrapping past the last channel.
  always_comb begin
    cand    = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < NUM_CHN; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CHN) idx = idx - NUM_CHN;
      sel = IW'(idx);
      if (!cand && !empty[sel]) begin
        cand    = 1'b1;
        gnt_idx = sel;
      end
    end
    rr_nxt = (gnt_idx == IW'(NUM_CHN - 1)) ? '0 : gnt_idx + IW'(1);
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    pop       = '0;
    out_en_d  = 1'b0;
    out_din_d = out_din_q;
`ifdef CHN_TAG_EN
    gnt_d     = gnt_q;
    case (state_q)
      HDR: begin
        if (!out_full) begin
          pop[gnt_q] = 1'b1;
          out_en_d   = 1'b1;
          out_din_d  = head[gnt_q];
          state_d    = DATA;
        end
      end
      default: begin
        if (!out_full && cand) begin
          gnt_d     = gnt_idx;
          rr_d      = rr_nxt;
          out_en_d  = 1'b1;
          out_din_d = {8'hA5, (DATA_W-8)'(gnt_idx)};
          state_d   = HDR;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
`else
    if (!out_full && cand) begin
      pop[gnt_idx] = 1'b1;
      rr_d         = rr_nxt;
      out_en_d     = 1'b1;
      out_din_d    = head[gnt_idx];
      state_d      = DATA;
    end else begin
      state_d = IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n || rst_all_fifo) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      out_en_q  <= 1'b0;
      out_din_q <= '0;
      ovf_q     <= '0;
`ifdef CHN_TAG_EN
      gnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      out_en_q  <= out_en_d;
      out_din_q <= out_din_d;
      ovf_q     <= ovf_d;
`ifdef CHN_TAG_EN
      gnt_q     <= gnt_d;
`endif
    end
  end

  assign out_en    = out_en_q;
  assign out_din   = out_din_q;
  assign overflow  = ovf_q;
  assign all_empty = (&empty) & ~out_en_q & (state_q == IDLE);
endmodule

// File: tb/tb_multi_chn_fifo_arbiter.sv
// Directed bench for multi_chn_fifo_arbiter; a scoreboard queue is checked by an output monitor.
module tb_multi_chn_fifo_arbiter;
  localparam int NUM_CHN    = 4;
  localparam int DATA_W     = 16;
  localparam int DEPTH_LOG2 = 4;
`ifdef CHN_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset_n, rst_all_fifo, out_full, out_en, all_empty;
  logic [NUM_CHN-1:0]        chn_enable, chn_din_en, overflow;
  logic [NUM_CHN*DATA_W-1:0] chn_din;
  logic [DATA_W-1:0]         out_din;

  int                n_tests = 0;
  int                n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  multi_chn_fifo_arbiter #(
    .NUM_CHN(NUM_CHN), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rst_all_fifo (rst_all_fifo),
    .chn_enable   (chn_enable),
    .chn_din      (chn_din),
    .chn_din_en   (chn_din_en),
    .out_full     (out_full),
    .out_din      (out_din),
    .out_en       (out_en),
    .overflow     (overflow),
    .all_empty    (all_empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_smp(input int chn, input logic [DATA_W-1:0] w);
    if (TAG) exp_q.push_back({8'hA5, 8'(chn)});
    exp_q.push_back(w);
  endtask

  task automatic set_din(input int chn, input logic [DATA_W-1:0] w);
    chn_din[chn*DATA_W +: DATA_W] = w;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      tick();
      if (all_empty && exp_q.size() == 0) done = 1'b1;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  // Output monitor: every written word must match the head of the scoreboard.
  initial begin
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (out_en === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_word: got 0x%0h, expected no word", out_din);
        end else begin
          e = exp_q.pop_front();
          if (out_din !== e) begin
            n_fail++;
            $display("FAIL out_word: got 0x%0h, expected 0x%0h", out_din, e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    rst_all_fifo = 1'b0;
    out_full     = 1'b0;
    chn_enable   = '0;
    chn_din      = '0;
    chn_din_en   = '0;
    tick();
    tick();
    chk("rst_out_en",    32'(out_en),    32'd0);
    chk("rst_out_din",   32'(out_din),   32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
    chk("rst_all_empty", 32'(all_empty), 32'd1);
    reset_n = 1'b1;
    tick();

    // Simultaneous samples on ch0/ch1: latency and back-to-back order.
    chn_enable = 4'b0011;
    set_din(0, 16'h1111);
    set_din(1, 16'h2222);
    chn_din_en = 4'b0011;
    push_smp(0, 16'h1111);
    push_smp(1, 16'h2222);
    tick();
    chn_din_en = '0;
    chk("t1_out_en_t1",   32'(out_en),    32'd0);
    chk("t1_busy",        32'(all_empty), 32'd0);
    tick();
    chk("t1_out_en_t2",   32'(out_en),  32'd1);
    chk("t1_first_word",  32'(out_din), TAG ? 32'hA500 : 32'h1111);
    tick();
    chk("t1_second_en",   32'(out_en),  32'd1);
    chk("t1_second_word", 32'(out_din), TAG ? 32'h1111 : 32'h2222);
    drain("t1_drain");

    // Only ch2 enabled; strobes on all channels.
    chn_enable = 4'b0100;
    for (int i = 0; i < NUM_CHN; i++) set_din(i, 16'(16'h3000 + i));
    chn_din_en = 4'b1111;
    push_smp(2, 16'h3002);
    tick();
    chn_din_en = '0;
    drain("t2_drain");
    chk("t2_overflow", 32'(overflow), 32'd0);

    // 17 samples into ch0 while full: 16 kept, overflow set.
    out_full   = 1'b1;
    chn_enable = 4'b0001;
    for (int k = 0; k < 17; k++) begin
      set_din(0, 16'(16'h4000 + k));
      chn_din_en = 4'b0001;
      tick();
    end
    chn_din_en = '0;
    tick();
    chk("t3_no_out_while_full", 32'(out_en),    32'd0);
    chk("t3_overflow_set",      32'(overflow),  32'd1);
    chk("t3_not_empty",         32'(all_empty), 32'd0);
    for (int k = 0; k < 16; k++) push_smp(0, 16'(16'h4000 + k));
    out_full = 1'b0;
    drain("t3_drain");
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);

    // Flush mid-drain of ch0 (last grant ch0, so a stale pointer would favour ch1 next).
    out_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_din(0, 16'(16'h6000 + k));
      chn_din_en = 4'b0001;
      tick();
    end
    chn_din_en = '0;
    exp_q.push_back(TAG ? 16'hA500 : 16'h6000);
    exp_q.push_back(TAG ? 16'h6000 : 16'h6001);
    out_full = 1'b0;
    tick();
    tick();
    rst_all_fifo = 1'b1;
    tick();
    rst_all_fifo = 1'b0;
    chk("t5_out_en_after_flush", 32'(out_en),       32'd0);
    chk("t5_all_empty",          32'(all_empty),    32'd1);
    chk("t5_overflow_cleared",   32'(overflow),     32'd0);
    chk("t5_words_before_flush", 32'(exp_q.size()), 32'd0);

    // Three words on ch0 and ch1 buffered, then released: strict alternation from ch0.
    out_full   = 1'b1;
    chn_enable = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      set_din(0, 16'(16'h5000 + k));
      set_din(1, 16'(16'h5100 + k));
      chn_din_en = 4'b0011;
      tick();
    end
    chn_din_en = '0;
    for (int k = 0; k < 3; k++) begin
      push_smp(0, 16'(16'h5000 + k));
      push_smp(1, 16'(16'h5100 + k));
    end
    out_full = 1'b0;
    drain("t4_drain");

`ifdef CHN_TAG_EN
    // Header/data pair on ch3 with full raised between the two words.
    chn_enable = 4'b1000;
    set_din(3, 16'h0ABC);
    chn_din_en = 4'b1000;
    exp_q.push_back(16'hA503);
    exp_q.push_back(16'h0ABC);
    tick();
    chn_din_en = '0;
    tick();
    chk("t6_hdr_en",   32'(out_en),  32'd1);
    chk("t6_hdr_word", 32'(out_din), 32'hA503);
    out_full = 1'b1;
    tick();
    chk("t6_hold_1", 32'(out_en), 32'd0);
    tick();
    chk("t6_hold_2", 32'(out_en), 32'd0);
    out_full = 1'b0;
    tick();
    chk("t6_data_en",   32'(out_en),  32'd1);
    chk("t6_data_word", 32'(out_din), 32'h0ABC);
    drain("t6_drain");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
